// File: rtl/rv_pkg.sv
// Shared types for the integer writeback path.
// Optional forwarding outputs are enabled by defining WB_FWD_EN.
package rv_pkg;
    localparam int XLEN = 32;
    typedef logic [4:0] reg_addr_t;
    typedef logic [XLEN-1:0] xlen_t;
    localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_writeback_unit_if.sv
// Result, issue, query and register-file write signals of the writeback unit.
// fwd* signals exist only when WB_FWD_EN is defined.
interface regfile_writeback_unit_if #(
    parameter int XLEN = 32
);
    import rv_pkg::*;

    logic            alu_valid;
    reg_addr_t       alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lat_valid;
    logic            lat_ready;
    reg_addr_t       lat_rd;
    logic [XLEN-1:0] lat_data;
    logic            iss_valid;
    reg_addr_t       iss_rd;
    reg_addr_t       q_rs1;
    reg_addr_t       q_rs2;
    logic            q_busy1;
    logic            q_busy2;
    logic            rf_we;
    reg_addr_t       rf_addr;
    logic [XLEN-1:0] rf_data;
    logic            sb_err;
`ifdef WB_FWD_EN
    logic            fwd1_hit;
    logic            fwd2_hit;
    logic [XLEN-1:0] fwd1_data;
    logic [XLEN-1:0] fwd2_data;
`endif

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lat_valid, lat_rd, lat_data,
        output iss_valid, iss_rd, q_rs1, q_rs2,
        input  lat_ready, q_busy1, q_busy2,
`ifdef WB_FWD_EN
        input  fwd1_hit, fwd2_hit, fwd1_data, fwd2_data,
`endif
        input  rf_we, rf_addr, rf_data, sb_err
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lat_valid, lat_rd, lat_data,
        input  iss_valid, iss_rd, q_rs1, q_rs2,
        output lat_ready, q_busy1, q_busy2,
`ifdef WB_FWD_EN
        output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data,
`endif
        output rf_we, rf_addr, rf_data, sb_err
    );
endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO for long-latency results; full is a registered flag.
// Pointers and count reset asynchronously, storage is not reset.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nx;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        cnt_nx = cnt;
        if (do_push && !do_pop)
            cnt_nx = cnt + 1'b1;
        else if (!do_push && do_pop)
            cnt_nx = cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            cnt  <= cnt_nx;
            full <= (cnt_nx == CW'(DEPTH));
        end
    end
endmodule

// File: rtl/regfile_writeback_unit.sv
// Merges ALU and buffered long-latency results into the register-file write port.
// Keeps the pending-write scoreboard; WB_FWD_EN adds write-port forwarding.
module regfile_writeback_unit
    import rv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int NREG  = 32
) (
    input logic clk,
    input logic rst,
    regfile_writeback_unit_if.slave wb
);
    localparam int EW = 5 + XLEN;

    logic [EW-1:0]   head;
    reg_addr_t       head_rd;
    logic [XLEN-1:0] head_data;
    logic            empty;
    logic            full;
    logic            pop;
    logic            push;
    logic [NREG-1:0] sb;
    logic [NREG-1:0] sb_nx;
    logic            busy1;
    logic            busy2;
    logic            dup_iss;

    assign push = wb.lat_valid && !full;
    assign pop  = !wb.alu_valid && !empty;
    assign {head_rd, head_data} = head;
    assign wb.lat_ready = !full;

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({wb.lat_rd, wb.lat_data}),
        .pop   (pop),
        .dout  (head),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb.rf_we   <= 1'b0;
            wb.rf_addr <= REG_ZERO;
            wb.rf_data <= '0;
        end else if (wb.alu_valid) begin
            wb.rf_we   <= (wb.alu_rd != REG_ZERO);
            wb.rf_addr <= wb.alu_rd;
            wb.rf_data <= wb.alu_data;
        end else if (pop) begin
            wb.rf_we   <= (head_rd != REG_ZERO);
            wb.rf_addr <= head_rd;
            wb.rf_data <= head_data;
        end else begin
            wb.rf_we   <= 1'b0;
        end
    end

    // Set is applied after clear so a same-cycle issue keeps the bit pending.
    always_comb begin
        sb_nx = sb;
        if (pop)
            sb_nx[head_rd] = 1'b0;
        if (wb.iss_valid && wb.iss_rd != REG_ZERO)
            sb_nx[wb.iss_rd] = 1'b1;
    end

    assign dup_iss = wb.iss_valid && (wb.iss_rd != REG_ZERO)
                  && sb[wb.iss_rd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb        <= '0;
            wb.sb_err <= 1'b0;
        end else begin
            sb <= sb_nx;
            if (dup_iss)
                wb.sb_err <= 1'b1;
        end
    end

    assign busy1 = (wb.q_rs1 != REG_ZERO) && sb[wb.q_rs1];
    assign busy2 = (wb.q_rs2 != REG_ZERO) && sb[wb.q_rs2];

`ifdef WB_FWD_EN
    assign wb.fwd1_hit = wb.rf_we && (wb.rf_addr == wb.q_rs1)
                      && (wb.q_rs1 != REG_ZERO);
    assign wb.fwd2_hit = wb.rf_we && (wb.rf_addr == wb.q_rs2)
                      && (wb.q_rs2 != REG_ZERO);
    assign wb.fwd1_data = wb.rf_data;
    assign wb.fwd2_data = wb.rf_data;
    assign wb.q_busy1 = busy1 && !wb.fwd1_hit;
    assign wb.q_busy2 = busy2 && !wb.fwd2_hit;
`else
    assign wb.q_busy1 = busy1;
    assign wb.q_busy2 = busy2;
`endif
endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Directed bench for regfile_writeback_unit: vector table plus multi-cycle sequences.
// Define WB_FWD_EN to also exercise the forwarding outputs.
module tb_regfile_writeback_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    regfile_writeback_unit_if #(.XLEN(32)) wb ();

    regfile_writeback_unit #(
        .XLEN  (32),
        .DEPTH (4),
        .NREG  (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    typedef struct {
        logic        alu_v;
        logic [4:0]  alu_rd;
        logic [31:0] alu_d;
        logic        iss_v;
        logic [4:0]  iss_rd;
        logic [4:0]  q1;
        logic [4:0]  q2;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        b1;
        logic        b2;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wb.alu_valid = 1'b0;
        wb.alu_rd    = 5'd0;
        wb.alu_data  = 32'd0;
        wb.lat_valid = 1'b0;
        wb.lat_rd    = 5'd0;
        wb.lat_data  = 32'd0;
        wb.iss_valid = 1'b0;
        wb.iss_rd    = 5'd0;
    endtask

    task automatic do_reset;
        idle();
        rst = 1'b1;
        #1;
        chk("rst_we", 32'(wb.rf_we), 32'd0);
        chk("rst_addr", 32'(wb.rf_addr), 32'd0);
        chk("rst_data", wb.rf_data, 32'd0);
        chk("rst_err", 32'(wb.sb_err), 32'd0);
        chk("rst_ready", 32'(wb.lat_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic exp_busy(logic b, logic we,
                                      logic [4:0] addr, logic [4:0] q);
`ifdef WB_FWD_EN
        return b && !(we && addr == q && q != 5'd0);
`else
        return b;
`endif
    endfunction

    initial begin
        idle();
        wb.q_rs1 = 5'd0;
        wb.q_rs2 = 5'd0;

        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,
                   5'd0, 5'd0,  1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,
                   5'd0, 5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b0};
        tbl[2] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0,
                   5'd31, 5'd0, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,
                   5'd7, 5'd5,  1'b0, 5'd0,  32'h0,        1'b1, 1'b0};
        tbl[4] = '{1'b1, 5'd7,  32'h00000001, 1'b1, 5'd12,
                   5'd7, 5'd12, 1'b1, 5'd7,  32'h00000001, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,
                   5'd0, 5'd12, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1};

        do_reset();
        for (int i = 0; i < 6; i++) begin
            wb.alu_valid = tbl[i].alu_v;
            wb.alu_rd    = tbl[i].alu_rd;
            wb.alu_data  = tbl[i].alu_d;
            wb.iss_valid = tbl[i].iss_v;
            wb.iss_rd    = tbl[i].iss_rd;
            wb.q_rs1     = tbl[i].q1;
            wb.q_rs2     = tbl[i].q2;
            tick();
            chk($sformatf("v%0d_we", i), 32'(wb.rf_we), 32'(tbl[i].we));
            if (tbl[i].we) begin
                chk($sformatf("v%0d_addr", i), 32'(wb.rf_addr),
                    32'(tbl[i].addr));
                chk($sformatf("v%0d_data", i), wb.rf_data, tbl[i].data);
            end
            chk($sformatf("v%0d_busy1", i), 32'(wb.q_busy1),
                32'(exp_busy(tbl[i].b1, tbl[i].we, tbl[i].addr, tbl[i].q1)));
            chk($sformatf("v%0d_busy2", i), 32'(wb.q_busy2),
                32'(exp_busy(tbl[i].b2, tbl[i].we, tbl[i].addr, tbl[i].q2)));
        end
        chk("tbl_err", 32'(wb.sb_err), 32'd0);

        // Scoreboard set then cleared by the long-latency write
        do_reset();
        wb.q_rs1 = 5'd7;
        wb.q_rs2 = 5'd0;
        wb.iss_valid = 1'b1;
        wb.iss_rd    = 5'd7;
        tick();
        wb.iss_valid = 1'b0;
        chk("sb_busy_set", 32'(wb.q_busy1), 32'd1);
        wb.lat_valid = 1'b1;
        wb.lat_rd    = 5'd7;
        wb.lat_data  = 32'hA5A5A5A5;
        tick();
        wb.lat_valid = 1'b0;
        chk("sb_we_n1", 32'(wb.rf_we), 32'd0);
        chk("sb_busy_n1", 32'(wb.q_busy1), 32'd1);
        tick();
        chk("sb_we_n2", 32'(wb.rf_we), 32'd1);
        chk("sb_addr_n2", 32'(wb.rf_addr), 32'd7);
        chk("sb_data_n2", wb.rf_data, 32'hA5A5A5A5);
        chk("sb_busy_n2", 32'(wb.q_busy1), 32'd0);

        // ALU results take priority over a queued entry
        do_reset();
        wb.lat_valid = 1'b1;
        wb.lat_rd    = 5'd9;
        wb.lat_data  = 32'h99;
        tick();
        wb.lat_valid = 1'b0;
        chk("col_we0", 32'(wb.rf_we), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            wb.alu_valid = 1'b1;
            wb.alu_rd    = 5'(i);
            wb.alu_data  = 32'h100 + 32'(i);
            tick();
            chk($sformatf("col_alu%0d_addr", i), 32'(wb.rf_addr), 32'(i));
            chk($sformatf("col_alu%0d_data", i), wb.rf_data,
                32'h100 + 32'(i));
        end
        wb.alu_valid = 1'b0;
        tick();
        chk("col_lat_we", 32'(wb.rf_we), 32'd1);
        chk("col_lat_addr", 32'(wb.rf_addr), 32'd9);
        chk("col_lat_data", wb.rf_data, 32'h99);
        tick();
        chk("col_idle_we", 32'(wb.rf_we), 32'd0);

        // FIFO fills while ALU holds the port, then drains in order
        do_reset();
        wb.alu_valid = 1'b1;
        wb.alu_rd    = 5'd20;
        wb.alu_data  = 32'h20;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_ready%0d", i), 32'(wb.lat_ready),
                (i < 4) ? 32'd1 : 32'd0);
            wb.lat_valid = 1'b1;
            wb.lat_rd    = 5'(10 + i);
            wb.lat_data  = 32'(100 + i);
            tick();
        end
        chk("bp_ready_full", 32'(wb.lat_ready), 32'd0);
        chk("bp_alu_addr", 32'(wb.rf_addr), 32'd20);
        wb.lat_valid = 1'b0;
        wb.alu_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk($sformatf("bp_we%0d", j), 32'(wb.rf_we), 32'd1);
            chk($sformatf("bp_addr%0d", j), 32'(wb.rf_addr), 32'(10 + j));
            chk($sformatf("bp_data%0d", j), wb.rf_data, 32'(100 + j));
        end
        tick();
        chk("bp_drained_we", 32'(wb.rf_we), 32'd0);
        chk("bp_ready_after", 32'(wb.lat_ready), 32'd1);

        // A popped rd=0 entry is consumed without a write
        do_reset();
        wb.lat_valid = 1'b1;
        wb.lat_rd    = 5'd0;
        wb.lat_data  = 32'h7;
        tick();
        wb.lat_rd    = 5'd4;
        wb.lat_data  = 32'h8;
        tick();
        wb.lat_valid = 1'b0;
        chk("x0_pop_we", 32'(wb.rf_we), 32'd0);
        tick();
        chk("x0_next_we", 32'(wb.rf_we), 32'd1);
        chk("x0_next_addr", 32'(wb.rf_addr), 32'd4);
        tick();
        chk("x0_empty_we", 32'(wb.rf_we), 32'd0);

        // Duplicate issue is sticky; reset mid-drain clears everything
        do_reset();
        wb.q_rs1 = 5'd3;
        wb.iss_valid = 1'b1;
        wb.iss_rd    = 5'd3;
        tick();
        chk("err_first", 32'(wb.sb_err), 32'd0);
        tick();
        wb.iss_valid = 1'b0;
        chk("err_dup", 32'(wb.sb_err), 32'd1);
        chk("err_busy", 32'(wb.q_busy1), 32'd1);
        tick();
        tick();
        chk("err_sticky", 32'(wb.sb_err), 32'd1);
        wb.lat_valid = 1'b1;
        wb.lat_rd    = 5'd4;
        wb.lat_data  = 32'h44;
        tick();
        wb.lat_rd    = 5'd5;
        wb.lat_data  = 32'h55;
        tick();
        wb.lat_valid = 1'b0;
        chk("mid_we", 32'(wb.rf_we), 32'd1);
        chk("mid_addr", 32'(wb.rf_addr), 32'd4);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_we", 32'(wb.rf_we), 32'd0);
        chk("mid_rst_err", 32'(wb.sb_err), 32'd0);
        chk("mid_rst_busy", 32'(wb.q_busy1), 32'd0);
        chk("mid_rst_ready", 32'(wb.lat_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("mid_after_we", 32'(wb.rf_we), 32'd0);

`ifdef WB_FWD_EN
        do_reset();
        wb.iss_valid = 1'b1;
        wb.iss_rd    = 5'd9;
        tick();
        wb.iss_valid = 1'b0;
        wb.q_rs2 = 5'd9;
        wb.q_rs1 = 5'd8;
        chk("fwd_pre_busy2", 32'(wb.q_busy2), 32'd1);
        wb.alu_valid = 1'b1;
        wb.alu_rd    = 5'd9;
        wb.alu_data  = 32'hCAFE0009;
        tick();
        wb.alu_valid = 1'b0;
        chk("fwd2_hit", 32'(wb.fwd2_hit), 32'd1);
        chk("fwd2_data", wb.fwd2_data, 32'hCAFE0009);
        chk("fwd_busy2", 32'(wb.q_busy2), 32'd0);
        chk("fwd1_hit", 32'(wb.fwd1_hit), 32'd0);
        tick();
        chk("fwd2_hit_off", 32'(wb.fwd2_hit), 32'd0);
        chk("fwd_busy2_back", 32'(wb.q_busy2), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
